load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Executes the memory access requested by the decoded control signals `mem_re`/`mem_we` and the load/store `instr_id`.
- Sits in the MEM stage between the EX/MEM pipeline register and the data-memory bus port.
- Generates the word-aligned bus request with byte enables and runs the request/grant/response handshake.
- Formats load data (sign or zero extension), stalls the pipeline while an access is outstanding, and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32 for RV32I, byte-enable width is DATA_W/8.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_re_i  in  1  load requested by the instruction in MEM.
- mem_we_i  in  1  store requested by the instruction in MEM.
- instr_id_i  in  `INST_ID_LEN  decoded instruction id; only LB/LH/LW/LBU/LHU/SB/SH/SW act.
- addr_i  in  ADDR_W  effective byte address from EX.
- wdata_i  in  DATA_W  rs2 value for stores.
- stall_o  out  1  freeze IF..MEM pipeline registers.
- done_o  out  1  one-cycle pulse; access complete.
- rdata_o  out  DATA_W  formatted load result, valid while done_o=1 for loads, 0 otherwise.
- misaligned_o  out  1  address misaligned for the access size; no bus activity.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1=write, 0=read.
- dmem_addr_o  out  ADDR_W  word address, bits[1:0]=0.
- dmem_be_o  out  DATA_W/8  byte enables.
- dmem_wdata_o  out  DATA_W  lane-replicated store data.
- dmem_gnt_i  in  1  bus accepted the request this cycle.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  DATA_W  raw read word.

Behaviour:
- Reset: state=IDLE. All outputs, including all bus outputs, are 0 from the cycle after rst is sampled high. Reset is honoured in every state; a pending request is dropped.
- Access acceptance: the access type comes from instr_id_i and requires the matching enable (load id with mem_re_i, store id with mem_we_i). Any other combination is ignored: no request, no stall.

State machine:
- IDLE:
  - Valid access, aligned: latch the address, size/sign, write flag, be and wdata; stall_o=1 combinationally; go to REQ.
  - Valid access, misaligned (H with addr[0]=1; W with addr[1:0]!=0): misaligned_o=1 combinationally, stall_o=0, stay in IDLE.
  - dmem_rvalid_i is ignored in IDLE.
- REQ:
  - dmem_req_o=1 with bus fields held stable from the latched values; stall_o=1.
  - dmem_gnt_i=1 on a store: go to DONE.
  - dmem_gnt_i=1 on a load: go to WAIT.
  - Otherwise hold indefinitely.
- WAIT:
  - req=0, stall_o=1.
  - dmem_rvalid_i=1: register the formatted data and go to DONE.
  - rvalid in the same cycle as gnt (in REQ) is not accepted; the response arrives at least one cycle after gnt.
- DONE:
  - done_o=1, stall_o=0, rdata_o valid; next state IDLE.
  - Inputs are ignored in DONE: they still show the just-completed instruction.

Latency and encodings:
- Minimum latency: store accept to done = 2 cycles (gnt in first REQ cycle); load = 3 cycles (rvalid the cycle after gnt).
- Byte enables:
  - B: 1<<addr[1:0].
  - H: 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1).
  - W: 4'b1111.
  - Loads drive the same be values.
- Store data: byte replicated to all 4 lanes; halfword replicated to both halves.
- Load format: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Back-to-back accesses: the next instruction is accepted in IDLE in the cycle after DONE, with no dead cycles beyond that.

Decomposition:
- Shared defines header: existing `INST_ID_LEN and load/store `*_ID codes; add `LSU_IDLE/`LSU_REQ/`LSU_WAIT/`LSU_DONE (2-bit) and `LSU_SIZE_B/H/W.
- One combinational sub-module, lsu_load_align: (raw word, addr[1:0], size, unsigned) -> extended result. It is reused by the bench reference model.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt the cycle after req -> dmem_addr=0x100, be=1111, we=1, done_o 2 cycles after accept, stall high for exactly 2 cycles.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, dmem_wdata=0xA5A5A5A5; SH addr=0x102, wdata=0x1234 -> be=1100, wdata=0x12341234.
- LB addr=0x201, rdata=0x0000_80FF; gnt delayed 3 cycles, rvalid 2 cycles later -> req held stable throughout, rdata_o=0xFFFFFF80 on done; LBU same -> 0x00000080.
- LW addr=0x202 -> misaligned_o=1 same cycle, dmem_req_o never asserts, stall_o=0; LH addr=0x201 -> misaligned_o=1.
- rst asserted in WAIT, rvalid arrives 1 cycle later -> all outputs 0, no done_o, state IDLE, rvalid ignored.
- mem_we_i=1 with instr_id=ADD_ID -> no request, no stall; two consecutive LW accesses -> second accepted the cycle after the first done_o.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// load_store_unit_pkg : shared ids, encodings and decode helpers for the LSU
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  localparam int INST_ID_LEN = 6;

  localparam logic [INST_ID_LEN-1:0] ADD_ID = 6'd0;
  localparam logic [INST_ID_LEN-1:0] LB_ID  = 6'd10;
  localparam logic [INST_ID_LEN-1:0] LH_ID  = 6'd11;
  localparam logic [INST_ID_LEN-1:0] LW_ID  = 6'd12;
  localparam logic [INST_ID_LEN-1:0] LBU_ID = 6'd13;
  localparam logic [INST_ID_LEN-1:0] LHU_ID = 6'd14;
  localparam logic [INST_ID_LEN-1:0] SB_ID  = 6'd15;
  localparam logic [INST_ID_LEN-1:0] SH_ID  = 6'd16;
  localparam logic [INST_ID_LEN-1:0] SW_ID  = 6'd17;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      valid;
    logic      store;
    lsu_size_e size;
    logic      uns;
  } lsu_op_t;

  // An id only counts as an access when its matching enable is also set.
  function automatic lsu_op_t lsu_decode(input logic [INST_ID_LEN-1:0] id,
                                         input logic re, input logic we);
    lsu_op_t op;
    op = '{valid: 1'b0, store: 1'b0, size: LSU_SIZE_W, uns: 1'b0};
    case (id)
      LB_ID:   op = '{valid: re, store: 1'b0, size: LSU_SIZE_B, uns: 1'b0};
      LH_ID:   op = '{valid: re, store: 1'b0, size: LSU_SIZE_H, uns: 1'b0};
      LW_ID:   op = '{valid: re, store: 1'b0, size: LSU_SIZE_W, uns: 1'b0};
      LBU_ID:  op = '{valid: re, store: 1'b0, size: LSU_SIZE_B, uns: 1'b1};
      LHU_ID:  op = '{valid: re, store: 1'b0, size: LSU_SIZE_H, uns: 1'b1};
      SB_ID:   op = '{valid: we, store: 1'b1, size: LSU_SIZE_B, uns: 1'b0};
      SH_ID:   op = '{valid: we, store: 1'b1, size: LSU_SIZE_H, uns: 1'b0};
      SW_ID:   op = '{valid: we, store: 1'b1, size: LSU_SIZE_W, uns: 1'b0};
      default: op = '{valid: 1'b0, store: 1'b0, size: LSU_SIZE_W, uns: 1'b0};
    endcase
    return op;
  endfunction

  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
    case (size)
      LSU_SIZE_H: return off[0];
      LSU_SIZE_W: return off != 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// ============================================================================
// lsu_load_align : selects the addressed lane of a read word and extends it
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  lsu_size_e   size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];
    case (size)
      LSU_SIZE_B: result = {{24{byte_lane[7] & ~uns}}, byte_lane};
      LSU_SIZE_H: result = {{16{half_lane[15] & ~uns}}, half_lane};
      default:    result = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : MEM-stage bus master with byte enables and load formatting
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_re_i,
  input  logic                   mem_we_i,
  input  logic [INST_ID_LEN-1:0] instr_id_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic                   stall_o,
  output logic                   done_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   misaligned_o,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [ADDR_W-1:0]      dmem_addr_o,
  output logic [DATA_W/8-1:0]    dmem_be_o,
  output logic [DATA_W-1:0]      dmem_wdata_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [DATA_W-1:0]      dmem_rdata_i
);

  lsu_state_e            state;
  lsu_op_t               op;
  logic                  mis;
  logic                  accept;
  logic [DATA_W/8-1:0]   be_calc;
  logic [DATA_W-1:0]     wdata_calc;
  logic [DATA_W-1:0]     aligned;

  logic [ADDR_W-1:0]     addr_q;
  logic [1:0]            off_q;
  lsu_size_e             size_q;
  logic                  uns_q;
  logic                  we_q;
  logic [DATA_W/8-1:0]   be_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;

  assign op     = lsu_decode(instr_id_i, mem_re_i, mem_we_i);
  assign mis    = op.valid && lsu_misaligned(op.size, addr_i[1:0]);
  assign accept = (state == LSU_IDLE) && op.valid && !mis && !rst;

  always_comb begin
    be_calc    = '0;
    wdata_calc = '0;
    case (op.size)
      LSU_SIZE_B: begin
        be_calc    = 4'b0001 << addr_i[1:0];
        wdata_calc = {4{wdata_i[7:0]}};
      end
      LSU_SIZE_H: begin
        be_calc    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata_i[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
      end
    endcase
  end

  lsu_load_align u_align (
    .word   (dmem_rdata_i),
    .offset (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LSU_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= LSU_SIZE_W;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
            off_q   <= addr_i[1:0];
            size_q  <= op.size;
            uns_q   <= op.uns;
            we_q    <= op.store;
            be_q    <= be_calc;
            wdata_q <= op.store ? wdata_calc : '0;
            rdata_q <= '0;
            state   <= LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (dmem_gnt_i) state <= we_q ? LSU_DONE : LSU_WAIT;
        end
        LSU_WAIT: begin
          if (dmem_rvalid_i) begin
            rdata_q <= aligned;
            state   <= LSU_DONE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  // Bus fields are only driven while the request is up; zero elsewhere.
  assign dmem_req_o   = (state == LSU_REQ);
  assign dmem_we_o    = dmem_req_o && we_q;
  assign dmem_addr_o  = dmem_req_o ? addr_q  : '0;
  assign dmem_be_o    = dmem_req_o ? be_q    : '0;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : '0;

  assign stall_o      = accept || (state == LSU_REQ) || (state == LSU_WAIT);
  assign misaligned_o = mis && (state == LSU_IDLE) && !rst;
  assign done_o       = (state == LSU_DONE);
  assign rdata_o      = (done_o && !we_q) ? rdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed stimulus with queue-based scoreboard monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   mem_re_i = 1'b0;
  logic                   mem_we_i = 1'b0;
  logic [INST_ID_LEN-1:0] instr_id_i = ADD_ID;
  logic [31:0]            addr_i = '0;
  logic [31:0]            wdata_i = '0;
  logic                   stall_o, done_o, misaligned_o;
  logic [31:0]            rdata_o;
  logic                   dmem_req_o, dmem_we_o;
  logic [31:0]            dmem_addr_o, dmem_wdata_o;
  logic [3:0]             dmem_be_o;
  logic                   dmem_gnt_i = 1'b0;
  logic                   dmem_rvalid_i = 1'b0;
  logic [31:0]            dmem_rdata_i = '0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .instr_id_i(instr_id_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .misaligned_o(misaligned_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares the bus request on each grant and the result on each done.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req_o && dmem_gnt_i) begin
        if (bus_q.size() == 0) check("unexpected_grant", 32'd1, 32'd0);
        else begin
          bus_exp_t b;
          b = bus_q.pop_front();
          check("bus_addr", dmem_addr_o, b.addr);
          check("bus_be", {28'd0, dmem_be_o}, {28'd0, b.be});
          check("bus_we", {31'd0, dmem_we_o}, {31'd0, b.we});
          if (b.we) check("bus_wdata", dmem_wdata_o, b.wdata);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_rdata", rdata_o, d.rdata);
          check("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  task automatic clear_inputs();
    mem_re_i = 1'b0; mem_we_i = 1'b0; instr_id_i = ADD_ID; addr_i = '0; wdata_i = '0;
  endtask

  task automatic access(input logic [INST_ID_LEN-1:0] id, input logic is_load,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                        input int gnt_dly, input int rv_dly,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                        output int acc_cyc);
    bus_exp_t  b;
    done_exp_t d;
    @(posedge clk); #1;
    instr_id_i = id; mem_re_i = is_load; mem_we_i = !is_load; addr_i = a; wdata_i = wd;
    @(negedge clk);
    check("accept_stall", {31'd0, stall_o}, 32'd1);
    acc_cyc = cyc;
    b.addr = e_addr; b.be = e_be; b.we = !is_load; b.wdata = e_wdata;
    bus_q.push_back(b);
    d.rdata = e_rdata;
    d.cyc   = cyc + 2 + gnt_dly + (is_load ? rv_dly : 0);
    done_q.push_back(d);
    @(posedge clk); #1;
    clear_inputs();
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      check("req_held", {31'd0, dmem_req_o}, 32'd1);
      check("req_addr_stable", dmem_addr_o, e_addr);
      check("req_be_stable", {28'd0, dmem_be_o}, {28'd0, e_be});
      @(posedge clk); #1;
    end
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    if (is_load) begin
      for (int i = 0; i < rv_dly - 1; i++) begin
        @(negedge clk);
        check("wait_no_req", {31'd0, dmem_req_o}, 32'd0);
        check("wait_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
      end
      dmem_rvalid_i = 1'b1; dmem_rdata_i = rword;
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    end
    @(negedge clk);
    check("done_no_stall", {31'd0, stall_o}, 32'd0);
    check("done_pulse", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, dummy;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_req", {31'd0, dmem_req_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_addr", dmem_addr_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Stores
    access(SW_ID, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, dummy);
    access(SB_ID, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0, dummy);
    access(SH_ID, 1'b0, 32'h102, 32'h00001234, 32'h0, 1, 0, 32'h100, 4'b1100, 32'h12341234, 32'h0, dummy);

    // Loads with delayed grant and response
    access(LB_ID,  1'b1, 32'h201, 32'h0, 32'h000080FF, 3, 2, 32'h200, 4'b0010, 32'h0, 32'hFFFFFF80, dummy);
    access(LBU_ID, 1'b1, 32'h201, 32'h0, 32'h000080FF, 3, 2, 32'h200, 4'b0010, 32'h0, 32'h00000080, dummy);
    access(LH_ID,  1'b1, 32'h202, 32'h0, 32'h80010000, 0, 1, 32'h200, 4'b1100, 32'h0, 32'hFFFF8001, dummy);
    access(LHU_ID, 1'b1, 32'h202, 32'h0, 32'h80010000, 0, 1, 32'h200, 4'b1100, 32'h0, 32'h00008001, dummy);

    // Misaligned accesses never reach the bus
    @(posedge clk); #1;
    instr_id_i = LW_ID; mem_re_i = 1'b1; addr_i = 32'h202;
    @(negedge clk);
    check("mis_lw_flag", {31'd0, misaligned_o}, 32'd1);
    check("mis_lw_stall", {31'd0, stall_o}, 32'd0);
    check("mis_lw_req", {31'd0, dmem_req_o}, 32'd0);
    @(posedge clk); #1;
    instr_id_i = LH_ID; addr_i = 32'h201;
    @(negedge clk);
    check("mis_lw_req_next", {31'd0, dmem_req_o}, 32'd0);
    check("mis_lh_flag", {31'd0, misaligned_o}, 32'd1);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("mis_lh_req_next", {31'd0, dmem_req_o}, 32'd0);

    // Non-memory id with write enable is ignored
    @(posedge clk); #1;
    instr_id_i = ADD_ID; mem_we_i = 1'b1; addr_i = 32'h100;
    @(negedge clk);
    check("add_stall", {31'd0, stall_o}, 32'd0);
    check("add_misaligned", {31'd0, misaligned_o}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("add_no_req", {31'd0, dmem_req_o}, 32'd0);

    // Reset while waiting for read data drops the access
    @(posedge clk); #1;
    instr_id_i = LW_ID; mem_re_i = 1'b1; addr_i = 32'h300;
    begin
      bus_exp_t b;
      b.addr = 32'h300; b.be = 4'b1111; b.we = 1'b0; b.wdata = 32'h0;
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    clear_inputs();
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    @(negedge clk);
    check("rst_wait_stall", {31'd0, stall_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    @(negedge clk);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    @(negedge clk);
    check("rst_rvalid_ignored", {31'd0, done_o}, 32'd0);

    // Back-to-back word loads
    access(LW_ID, 1'b1, 32'h300, 32'h0, 32'h11223344, 0, 1, 32'h300, 4'b1111, 32'h0, 32'h11223344, acc1);
    access(LW_ID, 1'b1, 32'h304, 32'h0, 32'hCAFEF00D, 0, 1, 32'h304, 4'b1111, 32'h0, 32'hCAFEF00D, acc2);
    check("back_to_back_gap", acc2 - acc1, 32'd4);

    repeat (3) @(posedge clk);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    check("done_queue_drained", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
